enhanced_decryption_module: RTL and testbench



---
 rtl/enhanced_decryption_module.sv | 140 ++++++++++++++
 tb/tb_enhanced_decryption_module.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/enhanced_decryption_module.sv
// Iterative decryptor for the 3-round nibble-substitution / rotate / key-XOR cipher, one round per clock.
// Optional DEC_ZEROIZE_EN: clears state, key_reg and data_out on the output handshake.
module enhanced_decryption_module #(
    parameter int unsigned N      = 8,
    parameter int unsigned ROUNDS = 3
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] data_in,
    input  logic [N-1:0] key,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] data_out
);

    localparam int unsigned RW  = (ROUNDS > 1) ? $clog2(ROUNDS) : 1;
    localparam int unsigned NIB = N / 4;
    localparam logic [RW-1:0] LAST_ROUND = RW'(ROUNDS - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } fsm_e;

    fsm_e          fsm_q, fsm_d;
    logic [N-1:0]  state_q, state_d;
    logic [N-1:0]  key_reg_q, key_reg_d;
    logic [RW-1:0] round_q, round_d;
    logic          out_valid_q, out_valid_d;
    logic          in_ready_q, in_ready_d;
    logic [N-1:0]  data_out_q, data_out_d;
    logic [N-1:0]  round_out;

    function automatic logic [3:0] inv_sbox(input logic [3:0] x);
        case (x)
            4'h0: inv_sbox = 4'd6;
            4'h1: inv_sbox = 4'd10;
            4'h2: inv_sbox = 4'd3;
            4'h3: inv_sbox = 4'd15;
            4'h4: inv_sbox = 4'd0;
            4'h5: inv_sbox = 4'd14;
            4'h6: inv_sbox = 4'd8;
            4'h7: inv_sbox = 4'd12;
            4'h8: inv_sbox = 4'd5;
            4'h9: inv_sbox = 4'd2;
            4'hA: inv_sbox = 4'd1;
            4'hB: inv_sbox = 4'd9;
            4'hC: inv_sbox = 4'd11;
            4'hD: inv_sbox = 4'd4;
            4'hE: inv_sbox = 4'd7;
            default: inv_sbox = 4'd13;
        endcase
    endfunction

    // One inverse round: undo key XOR, undo rotate-left, undo nibble S-box.
    function automatic logic [N-1:0] dec_round(input logic [N-1:0] s, input logic [N-1:0] k);
        logic [N-1:0] x;
        logic [N-1:0] r;
        logic [N-1:0] o;
        x = s ^ k;
        r = {x[0], x[N-1:1]};
        o = '0;
        for (int i = 0; i < int'(NIB); i++) begin
            o[4*i +: 4] = inv_sbox(r[4*i +: 4]);
        end
        return o;
    endfunction

    always_comb begin
        round_out = dec_round(state_q, key_reg_q ^ N'(round_q));
    end

    always_comb begin
        fsm_d      = fsm_q;
        state_d    = state_q;
        key_reg_d  = key_reg_q;
        round_d    = round_q;
        data_out_d = data_out_q;
        case (fsm_q)
            IDLE: begin
                if (in_valid) begin
                    state_d   = data_in;
                    key_reg_d = key;
                    round_d   = LAST_ROUND;
                    fsm_d     = RUN;
                end
            end
            RUN: begin
                state_d = round_out;
                if (round_q == '0) begin
                    data_out_d = round_out;
                    fsm_d      = DONE;
                end else begin
                    round_d = round_q - RW'(1);
                end
            end
            DONE: begin
                if (out_ready) begin
                    fsm_d = IDLE;
`ifdef DEC_ZEROIZE_EN
                    state_d    = '0;
                    key_reg_d  = '0;
                    data_out_d = '0;
`endif
                end
            end
            default: fsm_d = IDLE;
        endcase
        out_valid_d = (fsm_d == DONE);
        in_ready_d  = (fsm_d == IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            fsm_q       <= IDLE;
            state_q     <= '0;
            key_reg_q   <= '0;
            round_q     <= '0;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            data_out_q  <= '0;
        end else begin
            fsm_q       <= fsm_d;
            state_q     <= state_d;
            key_reg_q   <= key_reg_d;
            round_q     <= round_d;
            out_valid_q <= out_valid_d;
            in_ready_q  <= in_ready_d;
            data_out_q  <= data_out_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign data_out  = data_out_q;

endmodule

// File: tb/tb_enhanced_decryption_module.sv
// Self-checking bench for enhanced_decryption_module: brute-force reference decryptor plus a cycle timing model.
module tb_enhanced_decryption_module;

    localparam int ROUNDS = 3;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] data_in;
    logic [7:0] key;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] data_out;

    int n_checks = 0;
    int n_fail   = 0;

    enhanced_decryption_module #(.N(8), .ROUNDS(ROUNDS)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .data_in   (data_in),
        .key       (key),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .data_out  (data_out)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    logic [3:0] sbox [16] = '{4'd4, 4'd10, 4'd9, 4'd2, 4'd13, 4'd8, 4'd0, 4'd14,
                              4'd6, 4'd11, 4'd1, 4'd12, 4'd7, 4'd15, 4'd5, 4'd3};

    // Forward cipher as the encryption datapath defines it.
    function automatic logic [7:0] encrypt(input logic [7:0] p, input logic [7:0] k);
        logic [7:0] s;
        s = p;
        for (int r = 0; r < ROUNDS; r++) begin
            s = {sbox[s[7:4]], sbox[s[3:0]]};
            s = {s[6:0], s[7]};
            s = s ^ k ^ 8'(r);
        end
        return s;
    endfunction

    // Plaintext is the unique word whose encryption gives the ciphertext.
    function automatic logic [7:0] ref_decrypt(input logic [7:0] c, input logic [7:0] k);
        logic [7:0] res;
        res = 8'h00;
        for (int p = 0; p < 256; p++) begin
            if (encrypt(8'(p), k) == c) res = 8'(p);
        end
        return res;
    endfunction

    // Timing model: phase 0 idle, 1..ROUNDS running, ROUNDS+1 output presented.
    int         m_phase = 0;
    bit         m_live  = 1'b0;
    logic       m_valid = 1'b0;
    logic       m_ready = 1'b1;
    logic [7:0] m_data  = 8'h00;
    logic [7:0] m_exp   = 8'h00;

    always @(posedge clk) begin
        if (rst) begin
            m_live  = 1'b1;
            m_phase = 0;
            m_data  = 8'h00;
        end else if (m_phase == 0) begin
            if (in_valid) begin
                m_exp   = ref_decrypt(data_in, key);
                m_phase = 1;
            end
        end else if (m_phase <= ROUNDS) begin
            m_phase = m_phase + 1;
            if (m_phase == ROUNDS + 1) m_data = m_exp;
        end else if (out_ready) begin
            m_phase = 0;
`ifdef DEC_ZEROIZE_EN
            m_data = 8'h00;
`endif
        end
        m_valid = (m_phase == ROUNDS + 1);
        m_ready = (m_phase == 0);
    end

    always @(negedge clk) begin
        if (m_live && !rst) begin
            check("cmp_out_valid", 32'(out_valid), 32'(m_valid));
            check("cmp_in_ready", 32'(in_ready), 32'(m_ready));
            check("cmp_data_out", 32'(data_out), 32'(m_data));
        end
    end

    task automatic wait_out_valid(input string name, output int lat);
        lat = 0;
        while (!out_valid && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        check(name, 32'(lat), 32'(ROUNDS));
    endtask

    int lat;
    int cyc;
    int c1;
    int npulse;
    logic [7:0] d1;
    logic [7:0] d2;
    bit switched;

    initial begin
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; data_in = 8'h00; key = 8'h00;

        check("model_bb_3c", 32'(ref_decrypt(8'hBB, 8'h3C)), 32'h A5);
        check("model_fc_00", 32'(ref_decrypt(8'hFC, 8'h00)), 32'h00);

        repeat (2) @(negedge clk);
        rst = 1'b0;
        check("reset_out_valid", 32'(out_valid), 32'h0);
        check("reset_data_out", 32'(data_out), 32'h0);
        check("reset_in_ready", 32'(in_ready), 32'h1);
        check("reset_state", 32'(dut.state_q), 32'h0);
        check("reset_key_reg", 32'(dut.key_reg_q), 32'h0);

        // Single transaction 0xFC / 0x00.
        data_in = 8'hFC; key = 8'h00; in_valid = 1'b1; out_ready = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        wait_out_valid("fc_latency", lat);
        check("fc_data_out", 32'(data_out), 32'h00);
        @(negedge clk);
        check("fc_hs_out_valid", 32'(out_valid), 32'h0);
        check("fc_hs_in_ready", 32'(in_ready), 32'h1);

        // 0xBB / 0x3C with intermediate states and a stalled consumer.
        data_in = 8'hBB; key = 8'h3C; in_valid = 1'b1; out_ready = 1'b0;
        @(negedge clk);
        in_valid = 1'b0;
        check("bb_state_loaded", 32'(dut.state_q), 32'hBB);
        @(negedge clk);
        check("bb_state_r2", 32'(dut.state_q), 32'hB3);
        @(negedge clk);
        check("bb_state_r1", 32'(dut.state_q), 32'h0C);
        @(negedge clk);
        check("bb_state_r0", 32'(dut.state_q), 32'hA5);
        check("bb_out_valid", 32'(out_valid), 32'h1);
        check("bb_data_out", 32'(data_out), 32'hA5);
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1;
            data_in  = 8'(8'h11 * (i + 1));
            key      = ~key;
            @(negedge clk);
            check("stall_out_valid", 32'(out_valid), 32'h1);
            check("stall_data_out", 32'(data_out), 32'hA5);
            check("stall_in_ready", 32'(in_ready), 32'h0);
        end
        in_valid = 1'b0; out_ready = 1'b1;
        @(negedge clk);
        check("bb_hs_out_valid", 32'(out_valid), 32'h0);
`ifdef DEC_ZEROIZE_EN
        check("zero_data_out", 32'(data_out), 32'h00);
        check("zero_key_reg", 32'(dut.key_reg_q), 32'h00);
        check("zero_state", 32'(dut.state_q), 32'h00);
`else
        check("retain_data_out", 32'(data_out), 32'hA5);
        check("retain_key_reg", 32'(dut.key_reg_q), 32'h3C);
`endif

        // Reset during the second RUN cycle discards the transaction.
        data_in = 8'hBB; key = 8'h3C; in_valid = 1'b1; out_ready = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("midrst_in_ready", 32'(in_ready), 32'h1);
        check("midrst_data_out", 32'(data_out), 32'h00);
        npulse = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (out_valid) npulse++;
        end
        check("midrst_no_output", 32'(npulse), 32'h0);
        data_in = 8'hFC; key = 8'h00; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        wait_out_valid("midrst_fc_latency", lat);
        check("midrst_fc_data", 32'(data_out), 32'h00);
        @(negedge clk);

        // Back-to-back with in_valid and out_ready held high.
        data_in = 8'hFC; key = 8'h00; in_valid = 1'b1; out_ready = 1'b1;
        cyc = 0; c1 = 0; npulse = 0; d1 = 8'h00; d2 = 8'h00; switched = 1'b0;
        while (npulse < 2 && cyc < 40) begin
            @(negedge clk);
            cyc++;
            if (!switched && !in_ready) begin
                data_in = 8'hBB; key = 8'h3C; switched = 1'b1;
            end
            if (out_valid) begin
                if (npulse == 0) begin
                    c1 = cyc; d1 = data_out;
                end else begin
                    d2 = data_out;
                    in_valid = 1'b0;
                    check("b2b_spacing", 32'(cyc - c1), 32'd5);
                end
                npulse++;
            end
        end
        check("b2b_pulses", 32'(npulse), 32'd2);
        check("b2b_first_data", 32'(d1), 32'h00);
        check("b2b_second_data", 32'(d2), 32'hA5);
        in_valid = 1'b0;
        repeat (3) @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        n_fail++;
        $display("FAIL timeout: simulation did not complete, got running expected finished");
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
